// File: rtl/int_port_sched_if.sv
// Issue-port bundle between the issue queues and the integer-ALU port scheduler.
// Requests flow in, the held uop and per-requester grants flow out.
interface int_port_sched_if #(
  parameter int NUM_REQ   = 4,
  parameter int SQN_W     = 7,
  parameter int PAYLOAD_W = 128
);
  logic [NUM_REQ-1:0]                IN_reqValid;
  logic [NUM_REQ-1:0][SQN_W-1:0]     IN_reqSqN;
  logic [NUM_REQ-1:0][PAYLOAD_W-1:0] IN_reqPayload;
  logic [NUM_REQ-1:0]                OUT_reqGrant;
  logic                              IN_stall;
  logic                              IN_branchTaken;
  logic [SQN_W-1:0]                  IN_branchSqN;
  logic                              OUT_valid;
  logic [SQN_W-1:0]                  OUT_sqN;
  logic [PAYLOAD_W-1:0]              OUT_payload;
  logic [15:0]                       OUT_conflictCnt;

  modport slave (
    input  IN_reqValid, IN_reqSqN, IN_reqPayload, IN_stall, IN_branchTaken, IN_branchSqN,
    output OUT_reqGrant, OUT_valid, OUT_sqN, OUT_payload, OUT_conflictCnt
  );

  modport master (
    output IN_reqValid, IN_reqSqN, IN_reqPayload, IN_stall, IN_branchTaken, IN_branchSqN,
    input  OUT_reqGrant, OUT_valid, OUT_sqN, OUT_payload, OUT_conflictCnt
  );
endinterface

// File: rtl/int_port_sched.sv
// Oldest-first scheduler for one integer-ALU issue port, with a single held
// output uop that survives stalls and is cleared by branch flushes.
module int_port_sched_lane #(
  parameter int SQN_W = 7
) (
  input  logic [SQN_W-1:0] i_sqN,
  input  logic             i_brTaken,
  input  logic [SQN_W-1:0] i_brSqN,
  output logic             o_killed
);
  logic [SQN_W-1:0] w_diff;

  // Strictly younger than the branch (wrap-aware); equal sqN survives.
  assign w_diff   = i_sqN - i_brSqN;
  assign o_killed = i_brTaken && !w_diff[SQN_W-1] && (w_diff != '0);
endmodule

module int_port_sched #(
  parameter int NUM_REQ   = 4,
  parameter int SQN_W     = 7,
  parameter int PAYLOAD_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  int_port_sched_if.slave   bus
);
  logic [NUM_REQ-1:0]   w_kill;
  logic [NUM_REQ-1:0]   w_elig;
  logic [NUM_REQ-1:0]   w_win;
  logic [NUM_REQ-1:0]   w_grant;
  logic [SQN_W-1:0]     w_winSqN;
  logic [PAYLOAD_W-1:0] w_winPayload;
  logic                 w_heldKill;
  logic                 w_heldLive;
  logic                 w_free;
  logic                 w_multi;
  logic                 w_fire;

  logic                 r_valid;
  logic [SQN_W-1:0]     r_sqN;
  logic [PAYLOAD_W-1:0] r_payload;
  logic [15:0]          r_cnt;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      int_port_sched_lane #(.SQN_W(SQN_W)) u_lane (
        .i_sqN     (bus.IN_reqSqN[gi]),
        .i_brTaken (bus.IN_branchTaken),
        .i_brSqN   (bus.IN_branchSqN),
        .o_killed  (w_kill[gi])
      );
    end
  endgenerate

  int_port_sched_lane #(.SQN_W(SQN_W)) u_held (
    .i_sqN     (r_sqN),
    .i_brTaken (bus.IN_branchTaken),
    .i_brSqN   (bus.IN_branchSqN),
    .o_killed  (w_heldKill)
  );

  assign w_elig = bus.IN_reqValid & ~w_kill;

  // Pairwise age tournament: i wins if it beats every other eligible j.
  // Equal sqN resolves toward the lower index.
  always_comb begin
    logic [SQN_W-1:0] d_ij;
    logic [SQN_W-1:0] d_ji;
    d_ij  = '0;
    d_ji  = '0;
    w_win = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_win[i] = w_elig[i];
      for (int j = 0; j < NUM_REQ; j++) begin
        if (j != i && w_elig[j]) begin
          d_ij = bus.IN_reqSqN[i] - bus.IN_reqSqN[j];
          d_ji = bus.IN_reqSqN[j] - bus.IN_reqSqN[i];
          if (i < j) begin
            if (d_ji[SQN_W-1]) w_win[i] = 1'b0;
          end else begin
            if (!d_ij[SQN_W-1]) w_win[i] = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    w_winSqN     = '0;
    w_winPayload = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win[i]) begin
        w_winSqN     = w_winSqN | bus.IN_reqSqN[i];
        w_winPayload = w_winPayload | bus.IN_reqPayload[i];
      end
    end
  end

  // A flushed held uop frees the slot in the same cycle, even under stall.
  assign w_heldLive = r_valid && !w_heldKill;
  assign w_free     = !w_heldLive || !bus.IN_stall;
  assign w_multi    = |(w_elig & (w_elig - NUM_REQ'(1)));
  assign w_fire     = rst && w_free && (|w_elig);
  assign w_grant    = w_fire ? w_win : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid   <= 1'b0;
      r_sqN     <= '0;
      r_payload <= '0;
      r_cnt     <= '0;
    end else begin
      if (w_fire) begin
        r_valid   <= 1'b1;
        r_sqN     <= w_winSqN;
        r_payload <= w_winPayload;
      end else if (r_valid && w_heldKill) begin
        r_valid <= 1'b0;
      end else if (!bus.IN_stall) begin
        r_valid <= 1'b0;
      end
      if (w_multi && (r_cnt != 16'hFFFF)) r_cnt <= r_cnt + 16'd1;
    end
  end

  assign bus.OUT_reqGrant    = w_grant;
  assign bus.OUT_valid       = r_valid;
  assign bus.OUT_sqN         = r_sqN;
  assign bus.OUT_payload     = r_payload;
  assign bus.OUT_conflictCnt = r_cnt;
endmodule

// File: doc/int_port_sched.md
# int_port_sched

Oldest-first scheduler that shares one integer-ALU issue port between `NUM_REQ` issue-queue requesters. Each cycle it grants the oldest eligible request by sequence number (`sqN`) and captures it in a single output register that feeds the ALU's `IN_uop`. The output register holds its uop while the port is stalled. Branch flushes from `IN_branch` are applied both to incoming requests and to the held uop. Instances sit between the issue queues and each `IntALU`.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `SQN_W`, default 7: `sqN` width; age comparison uses wrap-around.
- `PAYLOAD_W`, default 128: opaque uop payload width.
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-low reset.
- `IN_reqValid` in `NUM_REQ`: request present.
- `IN_reqSqN` in `NUM_REQ*SQN_W`: per-request `sqN`; requester i uses bits `[i*SQN_W +: SQN_W]`.
- `IN_reqPayload` in `NUM_REQ*PAYLOAD_W`: per-request payload, packed the same way.
- `OUT_reqGrant` in/out: output, `NUM_REQ`, one-hot or zero, combinational. A request is consumed in any cycle where `IN_reqValid[i] && OUT_reqGrant[i]`.
- `IN_stall` in 1: ALU port cannot accept this cycle.
- `IN_branchTaken` in 1: flush valid.
- `IN_branchSqN` in `SQN_W`: flush point. Uops strictly younger than this are killed.
- `OUT_valid` out 1: held uop valid.
- `OUT_sqN` out `SQN_W`: held uop `sqN`.
- `OUT_payload` out `PAYLOAD_W`: held uop payload.
- `OUT_conflictCnt` out 16: saturating count of cycles where more than one request was eligible.

## Operation
- Age order: a is older than b iff `$signed(a - b) < 0`, computed at `SQN_W` bits, so wrap-around is handled.
- Kill rule: uop x is killed iff `IN_branchTaken && $signed(x - IN_branchSqN) > 0`. A uop equal to the branch `sqN` survives.
- Eligible(i): `IN_reqValid[i]` and not killed.
- Selection:
  - Pick the oldest eligible request.
  - Equal `sqN` values are a protocol violation. The tie-break is the lowest index.
- Free slot: `free = !OUT_valid || !IN_stall || killed(OUT_sqN)`.
- Grant: `OUT_reqGrant` is the one-hot of the selected request when `free` and at least one request is eligible; otherwise zero. Grant never depends on `OUT_reqGrant` itself, so there is no combinational loop.
- Output register update at the clock edge, in priority order:
  1. If a grant fires: load the winner's `sqN` and payload, set `OUT_valid=1`.
  2. Else if `OUT_valid` and the held uop is killed: `OUT_valid=0`.
  3. Else if `!IN_stall`: `OUT_valid=0`.
  4. Else hold `OUT_valid`, `OUT_sqN` and `OUT_payload` unchanged.
- Payload is captured verbatim; no interpretation of uop fields.
- Conflict counter: increments by 1 on each cycle with two or more eligible requests, independent of `free`. It saturates at `16'hFFFF`.
- Reset (`rst` low, asynchronous):
  - `OUT_valid=0`, `OUT_sqN=0`, `OUT_payload=0`, `OUT_conflictCnt=0`.
  - `OUT_reqGrant` is forced to zero while `rst` is low.
  - On release the block is idle. The first grant is possible in the first cycle after deassertion.
  - Reset asserted mid-stall drops the held uop with no grant issued.

## Timing
- Request to `OUT_valid`: 1 cycle. Grant is combinational in cycle N; the uop is visible from cycle N+1.
- Throughput: 1 uop per cycle with `IN_stall` low.
- Stall: the held uop is presented unchanged every stalled cycle. The new grant is issued in the same cycle `IN_stall` drops, so there is no bubble.
- Flush: takes effect the same cycle for both grants and the held uop. An older eligible request may be granted into a slot freed by a kill in that same cycle.
- `IN_stall` is ignored when `OUT_valid=0`.

## Test plan
- **Age pick:** reqs 0..3 valid with `sqN` 10, 5, 7, 12 and no stall → grant `4'b0010`; next cycle `OUT_valid=1`, `OUT_sqN=5`, and `OUT_conflictCnt=1`.
- **Wrap-around:** `SQN_W=7`, req0 `sqN=126`, req1 `sqN=2` → grant req0, since 126 is older.
- **Stall hold:** grant `sqN=3`, then `IN_stall=1` for 3 cycles with req2 valid → `OUT_reqGrant=0` and `OUT_sqN=3` held for 3 cycles. In the cycle stall drops, req2 is granted and appears the next cycle.
- **Flush:**
  - Held uop `sqN=20` under stall, `IN_branchTaken=1` with `IN_branchSqN=15`, req1 valid at `sqN=14` → req1 granted that cycle; next cycle `OUT_sqN=14`.
  - A request at `sqN=15` is granted and kept; one at `sqN=16` is never granted.
- **Saturation:** force two eligible requests for 70000 cycles → `OUT_conflictCnt` holds at `16'hFFFF`.
- **Reset mid-operation:** `OUT_valid=1` under stall, drive `rst` low between clock edges → `OUT_valid` and all other outputs go to 0 immediately, with no grant while low.
